// File: rtl/rom_stream_reader.sv
// Streams a programmable address window out of a 1-cycle-latency block ROM
// onto a valid/ready stream through a small prefetch FIFO.
module rom_stream_reader #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]       DEPTH_L = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]       CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0]     IDX_ONE = PW'(1);
    localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic              loop_q;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] issue_cnt;
    logic              inflight;
    logic              inflight_last;
    logic              done_q;

    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic              mem_last [FIFO_DEPTH];
    logic [PW-1:0]     wr_idx;
    logic [PW-1:0]     rd_idx;
    logic [PW:0]       count;
    logic [PW:0]       used;

    logic abort;
    logic issue;
    logic last_issue;
    logic push;
    logic pop;
    logic head_last;

    // Credit: words already buffered plus the one returning must leave room.
    assign used       = count + {{PW{1'b0}}, inflight};
    assign abort      = stop && (state != S_IDLE);
    assign issue      = (state == S_RUN) && !stop && (used < DEPTH_L);
    assign last_issue = (issue_cnt == len_q - A_ONE);
    assign push       = inflight;
    assign m_valid    = (count != '0);
    assign pop        = m_valid && m_ready;
    assign head_last  = mem_last[rd_idx];

    assign rom_en   = issue;
    assign rom_addr = issue ? rd_ptr : '0;
    assign m_data   = m_valid ? mem_data[rd_idx] : '0;
    assign m_last   = m_valid && head_last;
    assign busy     = (state != S_IDLE);
    assign done     = done_q;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_data[wr_idx] <= rom_dout;
            mem_last[wr_idx] <= inflight_last;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= S_IDLE;
            base_q        <= '0;
            len_q         <= '0;
            loop_q        <= 1'b0;
            rd_ptr        <= '0;
            issue_cnt     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done_q        <= 1'b0;
            wr_idx        <= '0;
            rd_idx        <= '0;
            count         <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state    <= S_IDLE;
                inflight <= 1'b0;
                wr_idx   <= '0;
                rd_idx   <= '0;
                count    <= '0;
            end else begin
                inflight      <= issue;
                inflight_last <= issue && last_issue;
                if (push) wr_idx <= wr_idx + IDX_ONE;
                if (pop)  rd_idx <= rd_idx + IDX_ONE;
                case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: ;
                endcase

                case (state)
                    S_IDLE: begin
                        if (start && !stop && (len != '0)) begin
                            base_q    <= base_addr;
                            len_q     <= len;
                            loop_q    <= loop_en;
                            rd_ptr    <= base_addr;
                            issue_cnt <= '0;
                            state     <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (issue) begin
                            if (last_issue && loop_q) begin
                                rd_ptr    <= base_q;
                                issue_cnt <= '0;
                            end else begin
                                rd_ptr    <= rd_ptr + A_ONE;
                                issue_cnt <= issue_cnt + A_ONE;
                                if (last_issue) state <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (pop && head_last) begin
                            done_q <= 1'b1;
                            state  <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader; ROM word at address a is {4'hA, a}.
module tb_rom_stream_reader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [11:0] base_addr = '0;
    logic [11:0] len = '0;
    logic        busy;
    logic        done;
    logic        rom_en;
    logic [11:0] rom_addr;
    logic [15:0] rom_dout = '0;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] got_data [64];
    logic        got_last [64];
    int ngot, ndone, cred_bad, busy_at_done, first_cyc, last_cyc;

    rom_stream_reader dut (
        .CLK(CLK), .RST(RST), .start(start), .stop(stop),
        .loop_en(loop_en), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_dout(rom_dout), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (rom_en) rom_dout <= {4'hA, rom_addr};

    task automatic launch(input logic [11:0] b, input logic [11:0] l,
                          input logic lp);
        @(negedge CLK);
        base_addr = b; len = l; loop_en = lp; start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    task automatic collect(input int nwant, input int maxcyc, input bit toggle);
        int issued, accepted;
        issued = 0; accepted = 0;
        ngot = 0; ndone = 0; cred_bad = 0; busy_at_done = 0;
        first_cyc = -1; last_cyc = -1;
        for (int c = 0; c < maxcyc; c++) begin
            @(negedge CLK);
            m_ready = (ngot < nwant) && (toggle ? c[0] : 1'b1);
            #1;
            if (done) begin
                ndone++;
                if (busy) busy_at_done = 1;
            end
            if (rom_en && (issued - accepted) >= 4) cred_bad++;
            if (rom_en) issued++;
            if (m_valid && m_ready && ngot < 64) begin
                got_data[ngot] = m_data;
                got_last[ngot] = m_last;
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                ngot++;
                accepted++;
            end
        end
        m_ready = 1'b0;
    endtask

    task automatic check_words(input string tag, input logic [11:0] b,
                               input int plen, input int n);
        logic [11:0] a;
        for (int i = 0; i < n; i++) begin
            a = b + 12'(i % plen);
            n_cmp++;
            if (got_data[i] !== {4'hA, a}) begin
                n_bad++;
                $display("FAIL %s data[%0d]: got %h want %h", tag, i,
                         got_data[i], {4'hA, a});
            end
            n_cmp++;
            if (got_last[i] !== ((i % plen) == plen - 1)) begin
                n_bad++;
                $display("FAIL %s last[%0d]: got %b want %b", tag, i,
                         got_last[i], ((i % plen) == plen - 1));
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if ({busy, done, rom_en, m_valid, m_last} !== 5'b0 ||
            rom_addr !== 12'h0 || m_data !== 16'h0) begin
            n_bad++;
            $display("FAIL reset outputs: got %b %h %h want 0", 
                     {busy, done, rom_en, m_valid, m_last}, rom_addr, m_data);
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_one_shot();
        launch(12'h010, 12'd4, 1'b0);
        collect(4, 15, 1'b0);
        n_cmp++;
        if (ngot !== 4) begin
            n_bad++; $display("FAIL oneshot count: got %0d want 4", ngot);
        end
        check_words("oneshot", 12'h010, 4, 4);
        n_cmp++;
        if (first_cyc < 2) begin
            n_bad++; $display("FAIL oneshot latency: got %0d want >=2", first_cyc);
        end
        n_cmp++;
        if (last_cyc - first_cyc !== 3) begin
            n_bad++;
            $display("FAIL oneshot rate: got span %0d want 3", last_cyc - first_cyc);
        end
        n_cmp++;
        if (ndone !== 1 || busy_at_done !== 0) begin
            n_bad++;
            $display("FAIL oneshot done: got %0d pulses busy %0d want 1 / 0",
                     ndone, busy_at_done);
        end
    endtask

    task automatic test_wrap();
        launch(12'hFFE, 12'd4, 1'b0);
        collect(4, 15, 1'b0);
        n_cmp++;
        if (ngot !== 4) begin
            n_bad++; $display("FAIL wrap count: got %0d want 4", ngot);
        end
        check_words("wrap", 12'hFFE, 4, 4);
    endtask

    task automatic test_backpressure();
        launch(12'h040, 12'd8, 1'b0);
        collect(8, 40, 1'b1);
        n_cmp++;
        if (ngot !== 8) begin
            n_bad++; $display("FAIL bp count: got %0d want 8", ngot);
        end
        check_words("bp", 12'h040, 8, 8);
        n_cmp++;
        if (cred_bad !== 0) begin
            n_bad++; $display("FAIL bp credit: got %0d overissues want 0", cred_bad);
        end
        n_cmp++;
        if (ndone !== 1) begin
            n_bad++; $display("FAIL bp done: got %0d want 1", ndone);
        end
    endtask

    task automatic test_loop();
        launch(12'h100, 12'd3, 1'b1);
        collect(10, 30, 1'b0);
        n_cmp++;
        if (ngot !== 10) begin
            n_bad++; $display("FAIL loop count: got %0d want 10", ngot);
        end
        check_words("loop", 12'h100, 3, 10);
        n_cmp++;
        if (ndone !== 0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL loop state: got done %0d busy %b want 0 / 1", ndone, busy);
        end
        @(negedge CLK);
        stop = 1'b1;
        @(posedge CLK);
        #1 stop = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL loop stop: got busy %b valid %b want 0 0", busy, m_valid);
        end
    endtask

    task automatic test_stop();
        int seen;
        launch(12'h200, 12'd100, 1'b0);
        m_ready = 1'b1;
        repeat (3) @(negedge CLK);
        stop = 1'b1;
        @(posedge CLK);
        #1 stop = 1'b0;
        n_cmp++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL stop: got valid %b busy %b want 0 0", m_valid, busy);
        end
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            if (done || m_valid || rom_en) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++; $display("FAIL stop quiet: got %0d active cycles want 0", seen);
        end
        launch(12'h300, 12'd2, 1'b0);
        collect(2, 12, 1'b0);
        n_cmp++;
        if (ngot !== 2 || ndone !== 1) begin
            n_bad++;
            $display("FAIL restart: got %0d words %0d done want 2 1", ngot, ndone);
        end
        check_words("restart", 12'h300, 2, 2);
    endtask

    task automatic test_len_zero_and_rst();
        launch(12'h050, 12'd0, 1'b0);
        n_cmp++;
        if (busy !== 1'b0 || rom_en !== 1'b0) begin
            n_bad++;
            $display("FAIL len0: got busy %b rom_en %b want 0 0", busy, rom_en);
        end
        launch(12'h400, 12'd50, 1'b0);
        m_ready = 1'b0;
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        n_cmp++;
        if ({busy, done, rom_en, m_valid, m_last} !== 5'b0 ||
            rom_addr !== 12'h0 || m_data !== 16'h0) begin
            n_bad++;
            $display("FAIL rst midrun: got %b %h %h want 0",
                     {busy, done, rom_en, m_valid, m_last}, rom_addr, m_data);
        end
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst discard: got valid %b busy %b want 0 0", m_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_wrap();
        test_backpressure();
        test_loop();
        test_stop();
        test_len_zero_and_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
